comp_seq: RTL and testbench
===========================

COMP_SEQ -- requirements
Module: comp_seq

Interface
REQ-001 The block SHALL have parameter XLEN, default 32, giving the operand width in bits.
REQ-002 The block SHALL have parameter CHUNK, default 8, giving the bits compared per cycle; XLEN SHALL be an integer multiple of CHUNK, and NCH = XLEN/CHUNK.
REQ-003 Port clk, input, 1 bit: the single clock; all state SHALL update on its rising edge.
REQ-004 Port rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 Port start, input, 1 bit: request a comparison; sampled only in IDLE or DONE.
REQ-006 Port kill, input, 1 bit: pipeline flush; aborts any comparison in progress.
REQ-007 Port rs1data, input, XLEN bits: operand 1, latched on start.
REQ-008 Port rs2data, input, XLEN bits: operand 2, latched on start.
REQ-009 Port funct3, input, 3 bits: comparison code, latched on start.
REQ-010 Port must_jump, input, 1 bit: unconditional-jump flag, latched on start.
REQ-011 Port busy, output, 1 bit: high while the state is RUN.
REQ-012 Port done, output, 1 bit: one-cycle pulse marking a valid result.
REQ-013 Port comp_out, output, 1 bit: comparison result, held from done until the next done.

Function
REQ-014 The funct3 codes SHALL map as follows: 000 EQ; 001 NE; 100 LT signed; 101 GE signed; 110 LTU; 111 GEU; 010 SLT signed-less; 011 SLTU unsigned-less.
REQ-015 The FSM SHALL have the states IDLE, RUN and DONE, with IDLE as the reset state.
REQ-016 On start with must_jump=0 in IDLE or DONE, the block SHALL latch operands and opcode, clear chunk index idx=0, set eq=1 and lt=0, and go to RUN.
REQ-017 On start with must_jump=1 in IDLE or DONE, the block SHALL go directly to DONE with comp_out=1 on the following cycle.
REQ-018 In each RUN cycle the block SHALL compare chunk NCH-1-idx (MSB first) only while eq=1: a difference SHALL set eq=0 and set lt=(rs1 chunk < rs2 chunk, unsigned); once eq=0, eq and lt SHALL NOT change.
REQ-019 For signed codes (100, 101, 010), operand bit XLEN-1 SHALL be inverted on latch so that the unsigned chunk compare yields the signed ordering.
REQ-020 RUN SHALL go to DONE when idx=NCH-1; otherwise idx SHALL increment by 1.
REQ-021 In DONE, done SHALL be 1 and comp_out SHALL be loaded with the result: EQ=eq, NE=~eq, LT/LTU/SLT/SLTU=lt, GE/GEU=~lt.
REQ-022 DONE SHALL go to IDLE, or to RUN/DONE if start is asserted that cycle, giving back-to-back operation.
REQ-023 Latency from start to done SHALL be NCH+1 cycles (5 at 32/8), or 1 cycle for must_jump.
REQ-024 start in RUN SHALL be ignored: no latching, and no effect on the comparison in progress.
REQ-025 kill in RUN or DONE SHALL force IDLE the next cycle with no done pulse and comp_out unchanged; kill SHALL take priority over a same-cycle start.
REQ-026 Equal operands SHALL yield eq=1 and lt=0 after all NCH chunks have been processed.

Reset
REQ-027 While rst=1, the block SHALL force state IDLE, idx=0, eq=1, lt=0, busy=0, done=0 and comp_out=0 on the next edge, including mid-RUN.
REQ-028 rst SHALL take priority over kill and start.

Configuration
REQ-029 With macro COMP_EARLY_EXIT_EN defined, RUN SHALL go to DONE on the cycle a chunk differs, giving a latency of k+2 cycles where k is the 0-based MSB-first index of the first differing chunk; equal operands still take NCH+1 cycles.
REQ-030 With COMP_EARLY_EXIT_EN undefined, the latency SHALL always be NCH+1 cycles, as in REQ-023.

Verification
REQ-031 XLEN=32, CHUNK=8, BLT, rs1=0x80000008, rs2=0x00000001 -> done in cycle 5, comp_out=1; the same operands with BLTU -> comp_out=0.
REQ-032 BGE with rs1=rs2=0x80000009 -> comp_out=1; BNE with the same operands -> comp_out=0; SLTU with rs1=0x00000001, rs2=0x80000001 -> comp_out=1.
REQ-033 must_jump=1 with funct3=000, rs1=1, rs2=2 -> done in cycle 1, comp_out=1; a second start on the done cycle with BEQ, rs1=rs2=0xA -> second done 5 cycles later, comp_out=1.
REQ-034 start with BEQ, rs1=rs2=5, then a start in cycle 2 with rs1=0, rs2=1 -> the second start is ignored, done in cycle 5 with comp_out=1; kill in cycle 3 of a new comparison -> no done, busy=0 the next cycle, comp_out unchanged.
REQ-035 rst asserted in cycle 2 of RUN -> the next cycle shows busy=0, done=0, comp_out=0, and no done ever follows.
REQ-036 With COMP_EARLY_EXIT_EN defined, BLTU with rs1=0x01000000, rs2=0x02000000 -> done in cycle 2, comp_out=1; with rs1=rs2 -> done in cycle 5.

Source files
------------

// File: rtl/comp_seq.sv
// Chunk-serial branch comparator: evaluates RISC-V style compare codes MSB chunk first.
// Optional macro COMP_EARLY_EXIT_EN finishes on the first differing chunk.
module comp_seq #(
  parameter int XLEN  = 32,
  parameter int CHUNK = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            kill,
  input  logic [XLEN-1:0] rs1data,
  input  logic [XLEN-1:0] rs2data,
  input  logic [2:0]      funct3,
  input  logic            must_jump,
  output logic            busy,
  output logic            done,
  output logic            comp_out
);

  localparam int NCH = XLEN / CHUNK;
  localparam int IW  = (NCH > 1) ? $clog2(NCH) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(NCH - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t          state_q;
  logic [XLEN-1:0] rs1_q, rs2_q;
  logic [2:0]      f3_q;
  logic [IW-1:0]   idx_q;
  logic            eq_q, lt_q;
  logic            busy_q, done_q, comp_q;

  logic [IW-1:0]    sel;
  logic [CHUNK-1:0] ch1, ch2;
  logic             eq_d, lt_d, exit_now;
  logic [XLEN-1:0]  sign_mask;

  function automatic logic is_signed(input logic [2:0] f);
    return (f == 3'b100) || (f == 3'b101) || (f == 3'b010);
  endfunction

  function automatic logic result(input logic [2:0] f, input logic eq, input logic lt);
    case (f)
      3'b000:  return eq;
      3'b001:  return ~eq;
      3'b101,
      3'b111:  return ~lt;
      default: return lt;
    endcase
  endfunction

  always_comb begin
    sel       = LAST_IDX - idx_q;
    ch1       = rs1_q[int'(sel)*CHUNK +: CHUNK];
    ch2       = rs2_q[int'(sel)*CHUNK +: CHUNK];
    eq_d      = eq_q;
    lt_d      = lt_q;
    // Once a chunk has differed the ordering is decided; lower chunks are ignored.
    if (eq_q && (ch1 != ch2)) begin
      eq_d = 1'b0;
      lt_d = (ch1 < ch2);
    end
`ifdef COMP_EARLY_EXIT_EN
    exit_now  = (idx_q == LAST_IDX) || !eq_d;
`else
    exit_now  = (idx_q == LAST_IDX);
`endif
    sign_mask = {is_signed(funct3), {(XLEN-1){1'b0}}};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      rs1_q   <= '0;
      rs2_q   <= '0;
      f3_q    <= '0;
      idx_q   <= '0;
      eq_q    <= 1'b1;
      lt_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      comp_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (kill) begin
        state_q <= S_IDLE;
        busy_q  <= 1'b0;
      end else begin
        case (state_q)
          S_IDLE, S_DONE: begin
            if (start && must_jump) begin
              state_q <= S_DONE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              comp_q  <= 1'b1;
            end else if (start) begin
              // Flipping the sign bit turns the unsigned chunk compare into a signed one.
              rs1_q   <= rs1data ^ sign_mask;
              rs2_q   <= rs2data ^ sign_mask;
              f3_q    <= funct3;
              idx_q   <= '0;
              eq_q    <= 1'b1;
              lt_q    <= 1'b0;
              state_q <= S_RUN;
              busy_q  <= 1'b1;
            end else begin
              state_q <= S_IDLE;
              busy_q  <= 1'b0;
            end
          end
          S_RUN: begin
            eq_q <= eq_d;
            lt_q <= lt_d;
            if (exit_now) begin
              state_q <= S_DONE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              comp_q  <= result(f3_q, eq_d, lt_d);
            end else begin
              idx_q <= idx_q + 1'b1;
            end
          end
          default: begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign comp_out = comp_q;

endmodule

// File: tb/tb_comp_seq.sv
// Directed bench for comp_seq at XLEN=32, CHUNK=8; expectations are hand-computed.
module tb_comp_seq;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        kill = 1'b0;
  logic [31:0] rs1data = '0;
  logic [31:0] rs2data = '0;
  logic [2:0]  funct3 = '0;
  logic        must_jump = 1'b0;
  logic        busy, done, comp_out;

  int nvec = 0;
  int nerr = 0;

`ifdef COMP_EARLY_EXIT_EN
  localparam bit EE = 1'b1;
`else
  localparam bit EE = 1'b0;
`endif

  comp_seq #(.XLEN(32), .CHUNK(8)) dut (
    .clk(clk), .rst(rst), .start(start), .kill(kill),
    .rs1data(rs1data), .rs2data(rs2data), .funct3(funct3), .must_jump(must_jump),
    .busy(busy), .done(done), .comp_out(comp_out)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issues one start and reports the cycle in which done appears (20 = never).
  task automatic measure(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                         input logic mj, output int lat, output logic co);
    funct3 = f; rs1data = a; rs2data = b; must_jump = mj; start = 1'b1;
    tick();
    start = 1'b0; must_jump = 1'b0;
    lat = 1;
    while (done !== 1'b1 && lat < 20) begin
      tick();
      lat++;
    end
    co = comp_out;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(); tick();
    nvec++; if (busy !== 1'b0) begin nerr++; $display("FAIL reset_busy got %b want 0", busy); end
    nvec++; if (done !== 1'b0) begin nerr++; $display("FAIL reset_done got %b want 0", done); end
    nvec++; if (comp_out !== 1'b0) begin nerr++; $display("FAIL reset_comp got %b want 0", comp_out); end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_codes();
    int lat; logic co;
    measure(3'b100, 32'h8000_0008, 32'h0000_0001, 1'b0, lat, co);
    nvec++; if (lat !== 5) begin nerr++; $display("FAIL blt_lat got %0d want 5", lat); end
    nvec++; if (co !== 1'b1) begin nerr++; $display("FAIL blt got %b want 1", co); end
    tick();
    nvec++; if (done !== 1'b0) begin nerr++; $display("FAIL done_pulse got %b want 0", done); end
    measure(3'b110, 32'h8000_0008, 32'h0000_0001, 1'b0, lat, co);
    nvec++; if (co !== 1'b0) begin nerr++; $display("FAIL bltu got %b want 0", co); end
    measure(3'b101, 32'h8000_0009, 32'h8000_0009, 1'b0, lat, co);
    nvec++; if (co !== 1'b1) begin nerr++; $display("FAIL bge_eq got %b want 1", co); end
    nvec++; if (lat !== 5) begin nerr++; $display("FAIL eq_lat got %0d want 5", lat); end
    measure(3'b001, 32'h8000_0009, 32'h8000_0009, 1'b0, lat, co);
    nvec++; if (co !== 1'b0) begin nerr++; $display("FAIL bne_eq got %b want 0", co); end
    measure(3'b011, 32'h0000_0001, 32'h8000_0001, 1'b0, lat, co);
    nvec++; if (co !== 1'b1) begin nerr++; $display("FAIL sltu got %b want 1", co); end
    measure(3'b010, 32'hFFFF_FFFB, 32'hFFFF_FFFD, 1'b0, lat, co);
    nvec++; if (co !== 1'b1) begin nerr++; $display("FAIL slt_neg got %b want 1", co); end
    measure(3'b101, 32'h7FFF_FFFF, 32'h8000_0000, 1'b0, lat, co);
    nvec++; if (co !== 1'b1) begin nerr++; $display("FAIL bge_max_min got %b want 1", co); end
    measure(3'b111, 32'h01FF_0000, 32'h0200_0000, 1'b0, lat, co);
    nvec++; if (co !== 1'b0) begin nerr++; $display("FAIL geu_freeze got %b want 0", co); end
    measure(3'b000, 32'h0000_1234, 32'h0000_1235, 1'b0, lat, co);
    nvec++; if (co !== 1'b0) begin nerr++; $display("FAIL beq_lsb got %b want 0", co); end
    tick();
  endtask

  task automatic test_back_to_back();
    int lat; logic co;
    measure(3'b000, 32'h1, 32'h2, 1'b1, lat, co);
    nvec++; if (lat !== 1) begin nerr++; $display("FAIL jump_lat got %0d want 1", lat); end
    nvec++; if (co !== 1'b1) begin nerr++; $display("FAIL jump got %b want 1", co); end
    measure(3'b000, 32'hA, 32'hA, 1'b0, lat, co);
    nvec++; if (lat !== 5) begin nerr++; $display("FAIL b2b_lat got %0d want 5", lat); end
    nvec++; if (co !== 1'b1) begin nerr++; $display("FAIL b2b got %b want 1", co); end
    tick();
  endtask

  task automatic test_start_ignored();
    int lat;
    funct3 = 3'b000; rs1data = 32'd5; rs2data = 32'd5; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    rs1data = 32'd0; rs2data = 32'd1; start = 1'b1;
    nvec++; if (busy !== 1'b1) begin nerr++; $display("FAIL run_busy got %b want 1", busy); end
    tick();
    start = 1'b0;
    lat = 3;
    while (done !== 1'b1 && lat < 20) begin tick(); lat++; end
    nvec++; if (lat !== 5) begin nerr++; $display("FAIL ign_lat got %0d want 5", lat); end
    nvec++; if (comp_out !== 1'b1) begin nerr++; $display("FAIL ign got %b want 1", comp_out); end
    tick();
  endtask

  task automatic test_kill();
    int lat; logic co; bit seen;
    funct3 = 3'b000; rs1data = 32'd1; rs2data = 32'd2; start = 1'b1;
    tick();
    start = 1'b0;
    tick(); tick();
    kill = 1'b1;
    tick();
    kill = 1'b0;
    nvec++; if (busy !== 1'b0) begin nerr++; $display("FAIL kill_busy got %b want 0", busy); end
    nvec++; if (comp_out !== 1'b1) begin nerr++; $display("FAIL kill_comp got %b want 1", comp_out); end
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin tick(); if (done === 1'b1) seen = 1'b1; end
    nvec++; if (seen !== 1'b0) begin nerr++; $display("FAIL kill_done got %b want 0", seen); end
    measure(3'b000, 32'd3, 32'd3, 1'b0, lat, co);
    kill = 1'b1; start = 1'b1; must_jump = 1'b1;
    tick();
    kill = 1'b0; start = 1'b0; must_jump = 1'b0;
    nvec++; if (done !== 1'b0) begin nerr++; $display("FAIL kill_prio got %b want 0", done); end
    tick();
  endtask

  task automatic test_reset_midrun();
    bit seen;
    funct3 = 3'b001; rs1data = 32'd1; rs2data = 32'd2; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    nvec++; if (busy !== 1'b0) begin nerr++; $display("FAIL rst_busy got %b want 0", busy); end
    nvec++; if (done !== 1'b0) begin nerr++; $display("FAIL rst_done got %b want 0", done); end
    nvec++; if (comp_out !== 1'b0) begin nerr++; $display("FAIL rst_comp got %b want 0", comp_out); end
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin tick(); if (done === 1'b1) seen = 1'b1; end
    nvec++; if (seen !== 1'b0) begin nerr++; $display("FAIL rst_nodone got %b want 0", seen); end
  endtask

  task automatic test_early_exit();
    int lat; logic co; int exp;
    measure(3'b110, 32'h0100_0000, 32'h0200_0000, 1'b0, lat, co);
    exp = EE ? 2 : 5;
    nvec++; if (lat !== exp) begin nerr++; $display("FAIL ee_k0_lat got %0d want %0d", lat, exp); end
    nvec++; if (co !== 1'b1) begin nerr++; $display("FAIL ee_k0 got %b want 1", co); end
    measure(3'b110, 32'h0000_1000, 32'h0000_2000, 1'b0, lat, co);
    exp = EE ? 4 : 5;
    nvec++; if (lat !== exp) begin nerr++; $display("FAIL ee_k2_lat got %0d want %0d", lat, exp); end
    measure(3'b110, 32'h0100_0000, 32'h0100_0000, 1'b0, lat, co);
    nvec++; if (lat !== 5) begin nerr++; $display("FAIL ee_eq_lat got %0d want 5", lat); end
    nvec++; if (co !== 1'b0) begin nerr++; $display("FAIL ee_eq got %b want 0", co); end
    tick();
  endtask

  initial begin
    test_reset();
    test_codes();
    test_back_to_back();
    test_start_ignored();
    test_kill();
    test_reset_midrun();
    test_early_exit();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
